// File: rtl/pkt_stream_sequencer.sv
// Purpose: resolves each packet's flow key to a 6-bit stream ID and feeds the regex bank one character per cycle.
// Latency: load_state 2 cycles after the sop word is accepted; first char LOAD_GAP+1 cycles later; eop EOP_DELAY+1 after the last char.
// Backpressure: in_rdy is high in IDLE, and in BYTES on the last byte of a non-eop word or while waiting for a word; otherwise low.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_data/in_vld/in_rdy         32-bit packet word handshake, byte [31:24] first
//   in_sop/in_eop/in_nbytes       packet framing; in_nbytes=0 means 4 bytes in the eop word
//   in_key                        flow key, sampled with the accepted sop word
//   char_in/char_in_vld           character stream to the matchers
//   load_state/stream_id/new_stream_id  start-of-packet pulse and resolved stream ID
//   eop                           end-of-packet pulse
//   drop_cnt                      saturating count of words dropped outside a packet
module pkt_stream_sequencer #(
  parameter int LOAD_GAP  = 1,
  parameter int EOP_DELAY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_nbytes,
  input  logic [31:0] in_key,
  output logic [7:0]  char_in,
  output logic        char_in_vld,
  output logic        load_state,
  output logic [5:0]  stream_id,
  output logic        new_stream_id,
  output logic        eop,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_BYTES, S_DRAIN, S_EOP
  } state_t;

  localparam logic [7:0] GAP_LAST   = 8'(LOAD_GAP  > 0 ? LOAD_GAP  - 1 : 0);
  localparam logic [7:0] DRAIN_LAST = 8'(EOP_DELAY > 0 ? EOP_DELAY - 1 : 0);

  state_t      r_state, w_next;

  logic [31:0] r_word;
  logic        r_word_vld;     // word register still holds unsent bytes
  logic        r_last;         // word register holds the eop word
  logic [1:0]  r_last_idx;     // index of the final valid byte in the word register
  logic [1:0]  r_idx;
  logic [31:0] r_key;
  logic        r_hit;
  logic [5:0]  r_hit_idx;
  logic [5:0]  r_alloc_ptr;
  logic [5:0]  r_stream_id;
  logic [7:0]  r_char;
  logic [15:0] r_drop_cnt;
  logic [7:0]  r_cnt;
  logic [31:0] r_tbl_key [64];
  logic [63:0] r_tbl_vld;

  logic        w_lk_hit;
  logic [5:0]  w_lk_idx;
  logic [7:0]  w_byte;
  logic        w_last_byte;
  logic [1:0]  w_in_last_idx;
  logic [5:0]  w_sid;
  logic        w_rdy, w_cvld, w_load, w_new, w_eop;
  logic        w_cap;

  // Parallel compare; allocation only on a miss keeps at most one match.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_idx = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (r_tbl_vld[i] && (r_tbl_key[i] == r_key)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = 6'(i);
      end
    end
  end

  assign w_byte        = 8'(r_word >> {~r_idx, 3'b000});
  assign w_last_byte   = (r_idx == r_last_idx);
  assign w_in_last_idx = in_eop ? (in_nbytes - 2'd1) : 2'd3;
  assign w_sid         = r_hit ? r_hit_idx : r_alloc_ptr;
  // A word is loaded either as the sop word in IDLE or as any word in BYTES.
  assign w_cap         = w_rdy && in_vld && ((r_state == S_BYTES) || in_sop);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b0;
    w_cvld = 1'b0;
    w_load = 1'b0;
    w_new  = 1'b0;
    w_eop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rdy = 1'b1;
        if (in_vld && in_sop) w_next = S_LOOKUP;
      end
      S_LOOKUP: w_next = S_LOAD;
      S_LOAD: begin
        w_load = 1'b1;
        w_new  = ~r_hit;
        w_next = (LOAD_GAP > 0) ? S_GAP : S_BYTES;
      end
      S_GAP: if (r_cnt == GAP_LAST) w_next = S_BYTES;
      S_BYTES: begin
        if (r_word_vld) begin
          w_cvld = 1'b1;
          if (w_last_byte) begin
            if (r_last) w_next = (EOP_DELAY > 0) ? S_DRAIN : S_EOP;
            else        w_rdy  = 1'b1;
          end
        end else begin
          w_rdy = 1'b1;
        end
      end
      S_DRAIN: if (r_cnt == DRAIN_LAST) w_next = S_EOP;
      S_EOP: begin
        w_eop  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word      <= '0;
      r_word_vld  <= 1'b0;
      r_last      <= 1'b0;
      r_last_idx  <= '0;
      r_idx       <= '0;
      r_key       <= '0;
      r_hit       <= 1'b0;
      r_hit_idx   <= '0;
      r_alloc_ptr <= '0;
      r_stream_id <= '0;
      r_char      <= '0;
      r_drop_cnt  <= '0;
      r_cnt       <= '0;
      r_tbl_vld   <= '0;
    end else begin
      r_cnt <= ((r_state == S_GAP) || (r_state == S_DRAIN)) ? r_cnt + 8'd1 : 8'd0;

      if (w_cap) begin
        r_word     <= in_data;
        r_word_vld <= 1'b1;
        r_last     <= in_eop;
        r_last_idx <= w_in_last_idx;
        r_idx      <= '0;
      end else if ((r_state == S_BYTES) && r_word_vld) begin
        if (w_last_byte) r_word_vld <= 1'b0;
        else             r_idx      <= r_idx + 2'd1;
      end

      if ((r_state == S_IDLE) && in_vld && in_sop) r_key <= in_key;

      if ((r_state == S_IDLE) && in_vld && !in_sop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;

      if (r_state == S_LOOKUP) begin
        r_hit     <= w_lk_hit;
        r_hit_idx <= w_lk_idx;
      end

      // On a miss (including a full table) the FIFO slot at alloc_ptr is claimed.
      if (r_state == S_LOAD) begin
        r_stream_id <= w_sid;
        if (!r_hit) begin
          r_tbl_vld[r_alloc_ptr] <= 1'b1;
          r_alloc_ptr            <= r_alloc_ptr + 6'd1;
        end
      end

      if (w_cvld) r_char <= w_byte;
    end
  end

  // Key storage needs no reset: entries are qualified by r_tbl_vld.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_LOAD) && !r_hit) r_tbl_key[r_alloc_ptr] <= r_key;
  end

  assign in_rdy        = w_rdy & ~rst;
  assign char_in_vld   = w_cvld & ~rst;
  assign char_in       = rst ? 8'd0 : (w_cvld ? w_byte : r_char);
  assign load_state    = w_load & ~rst;
  assign new_stream_id = w_new & ~rst;
  assign stream_id     = rst ? 6'd0 : ((r_state == S_LOAD) ? w_sid : r_stream_id);
  assign eop           = w_eop & ~rst;
  assign drop_cnt      = rst ? 16'd0 : r_drop_cnt;

endmodule
